axi2core: RTL
=============

AXI2CORE -- requirements
Module: axi2core

Interface
REQ-001 SHALL have parameter AXI4_ADDRESS_WIDTH, default 32, meaning AXI and core address width (AW).
REQ-002 SHALL have parameter AXI4_ID_WIDTH, default 16, meaning AXI ID width (IW); data width is fixed at 32.
REQ-003 clk_i  in  1  single clock, all logic on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 aw_id_i/aw_addr_i/aw_len_i/aw_burst_i  in  IW/AW/8/2; aw_valid_i in 1; aw_ready_o out 1.
REQ-006 w_data_i/w_strb_i/w_last_i/w_valid_i  in  32/4/1/1; w_ready_o out 1.
REQ-007 b_id_o/b_resp_o/b_valid_o  out  IW/2/1; b_ready_i in 1.
REQ-008 ar_id_i/ar_addr_i/ar_len_i/ar_burst_i  in  IW/AW/8/2; ar_valid_i in 1; ar_ready_o out 1.
REQ-009 r_id_o/r_data_o/r_resp_o/r_last_o/r_valid_o  out  IW/32/2/1/1; r_ready_i in 1.
REQ-010 data_req_o/data_we_o  out  1/1; data_addr_o out AW; data_be_o out 4; data_wdata_o out 32.
REQ-011 data_gnt_i/data_rvalid_i  in  1/1; data_rdata_i in 32; core-side request/grant/valid memory port.

Function
REQ-012 States SHALL be IDLE, READ_REQ, READ_WAIT, READ_RESP, WRITE_REQ, WRITE_WAIT, WRITE_RESP; one AXI transaction and one core request in flight at most.
REQ-013 IDLE: ar_valid_i and no aw_valid_i -> ar_ready_o=1, capture id/addr/len/burst, beat=0, -> READ_REQ.
REQ-014 IDLE: aw_valid_i and no ar_valid_i -> aw_ready_o=1, capture, beat=0, err=0, -> WRITE_REQ.
REQ-015 IDLE both valid: read wins (see REQ-030); aw_ready_o/ar_ready_o SHALL be 0 outside IDLE.
REQ-016 data_addr_o = {addr[AW-1:2],2'b00}; burst 2'b00 (FIXED) keeps addr; any other burst adds 4 per beat, modulo 2^AW.
REQ-017 READ_REQ: data_req_o=1, data_we_o=0, data_be_o=4'hF; on data_gnt_i -> READ_WAIT.
REQ-018 READ_WAIT: on data_rvalid_i register data_rdata_i -> READ_RESP.
REQ-019 READ_RESP: r_valid_o=1, r_data_o=registered data, r_id_o=captured id, r_resp_o=2'b00, r_last_o=(beat==len).
REQ-020 READ_RESP on r_ready_i: last -> IDLE; else beat+1, address advance, -> READ_REQ; r_* SHALL hold stable while r_ready_i=0.
REQ-021 WRITE_REQ: data_req_o=w_valid_i, data_we_o=1, data_wdata_o=w_data_i, data_be_o=w_strb_i; w_ready_o=data_gnt_i (combinational).
REQ-022 WRITE_REQ on data_gnt_i&w_valid_i -> WRITE_WAIT; if w_last_i != (beat==len), err SHALL set (sticky).
REQ-023 WRITE_WAIT on data_rvalid_i: last -> WRITE_RESP; else beat+1, address advance, -> WRITE_REQ.
REQ-024 WRITE_RESP: b_valid_o=1, b_id_o=captured id, b_resp_o = err ? 2'b10 : 2'b00; on b_ready_i -> IDLE.
REQ-025 data_gnt_i while data_req_o=0, and data_rvalid_i outside READ_WAIT/WRITE_WAIT, SHALL be ignored.
REQ-026 Latency: AR handshake to first data_req_o 1 cycle; data_rvalid_i to r_valid_o 1 cycle; len=255 SHALL yield 256 beats.

Reset
REQ-027 rst_ni low SHALL force IDLE, beat=0, err=0, registered data=0, arbitration flag=0, regardless of in-flight transfer.
REQ-028 During reset all outputs SHALL be 0 (valid/ready/req low, ids, data, resp, addr zero).
REQ-029 An in-flight core request SHALL be abandoned on reset; late data_rvalid_i after reset is ignored.

Configuration
REQ-030 Macro AXI2CORE_RR_ARB_EN: defined -> flag records last serviced type, simultaneous AR/AW grants the other type (flag reset = write, so read first); undefined -> read always wins, no flag.

Verification
REQ-031 AR id=3 addr=0x100 len=3 INCR, core gnt immediate, rvalid+1 -> reads 0x100,0x104,0x108,0x10C, 4 R beats id=3, r_last only on 4th.
REQ-032 AW id=5 addr=0x20 len=1 FIXED, two W beats strb 4'h3/4'hC, w_last on 2nd -> two core writes at 0x20, b_resp=2'b00, b_id=5.
REQ-033 AW len=2, w_last_i on beat 1 -> 3 core writes, b_resp=2'b10.
REQ-034 AR and AW valid same cycle twice -> default: read, read; with AXI2CORE_RR_ARB_EN: read then write.
REQ-035 r_ready_i low 5 cycles in READ_RESP -> r_data_o stable, no new data_req_o; rst_ni low mid-burst -> IDLE, outputs 0 next edge.
REQ-036 AR addr=0xFFFFFFFC len=1 INCR -> second core read at 0x00000000.

Source files
------------

// File: rtl/axi2core.sv
// rtl/axi2core.sv - AXI4 slave to single-port core memory bridge, one beat in flight at a time
// Optional macro AXI2CORE_RR_ARB_EN: alternate AR/AW service when both arrive together.
module axi2core #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                    aw_len_i,
    input  logic [1:0]                    aw_burst_i,
    input  logic                          aw_valid_i,
    output logic                          aw_ready_o,
    input  logic [31:0]                   w_data_i,
    input  logic [3:0]                    w_strb_i,
    input  logic                          w_last_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
    output logic [1:0]                    b_resp_o,
    output logic                          b_valid_o,
    input  logic                          b_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]                    ar_len_i,
    input  logic [1:0]                    ar_burst_i,
    input  logic                          ar_valid_i,
    output logic                          ar_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
    output logic [31:0]                   r_data_o,
    output logic [1:0]                    r_resp_o,
    output logic                          r_last_o,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    output logic                          data_req_o,
    output logic                          data_we_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_o,
    output logic [3:0]                    data_be_o,
    output logic [31:0]                   data_wdata_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    input  logic [31:0]                   data_rdata_i
);
    localparam int AW = AXI4_ADDRESS_WIDTH;
    localparam int IW = AXI4_ID_WIDTH;

    typedef enum logic [2:0] {
        IDLE, READ_REQ, READ_WAIT, READ_RESP, WRITE_REQ, WRITE_WAIT, WRITE_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic [1:0]    burst_q, burst_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          pick_rd, pick_wr, last_beat;
    logic [AW-1:0] addr_next;

    assign last_beat = (beat_q == len_q);
    assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + AW'(4);

`ifdef AXI2CORE_RR_ARB_EN
    // 1 = a read was serviced last; reset value 0 lets the first contested grant go to the read
    logic rd_last_q, rd_last_d;
    assign pick_rd = ar_valid_i && (!aw_valid_i || !rd_last_q);
`else
    assign pick_rd = ar_valid_i;
`endif
    assign pick_wr = aw_valid_i && !pick_rd;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef AXI2CORE_RR_ARB_EN
        rd_last_d = rd_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_rd) begin
                    id_d    = ar_id_i;
                    addr_d  = ar_addr_i;
                    len_d   = ar_len_i;
                    burst_d = ar_burst_i;
                    beat_d  = 8'd0;
                    state_d = READ_REQ;
`ifdef AXI2CORE_RR_ARB_EN
                    rd_last_d = 1'b1;
`endif
                end else if (pick_wr) begin
                    id_d    = aw_id_i;
                    addr_d  = aw_addr_i;
                    len_d   = aw_len_i;
                    burst_d = aw_burst_i;
                    beat_d  = 8'd0;
                    err_d   = 1'b0;
                    state_d = WRITE_REQ;
`ifdef AXI2CORE_RR_ARB_EN
                    rd_last_d = 1'b0;
`endif
                end
            end
            READ_REQ: if (data_gnt_i) state_d = READ_WAIT;
            READ_WAIT: begin
                if (data_rvalid_i) begin
                    rdata_d = data_rdata_i;
                    state_d = READ_RESP;
                end
            end
            READ_RESP: begin
                if (r_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = READ_REQ;
                    end
                end
            end
            WRITE_REQ: begin
                if (data_gnt_i && w_valid_i) begin
                    if (w_last_i != last_beat) err_d = 1'b1;
                    state_d = WRITE_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (data_rvalid_i) begin
                    if (last_beat) begin
                        state_d = WRITE_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = WRITE_REQ;
                    end
                end
            end
            WRITE_RESP: if (b_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from the registered state; rst_ni gating keeps the IDLE readies low in reset
    always_comb begin
        aw_ready_o   = 1'b0;
        ar_ready_o   = 1'b0;
        w_ready_o    = 1'b0;
        b_id_o       = '0;
        b_resp_o     = 2'b00;
        b_valid_o    = 1'b0;
        r_id_o       = '0;
        r_data_o     = 32'h0;
        r_resp_o     = 2'b00;
        r_last_o     = 1'b0;
        r_valid_o    = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_addr_o  = '0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    ar_ready_o = pick_rd;
                    aw_ready_o = pick_wr;
                end
                READ_REQ: begin
                    data_req_o  = 1'b1;
                    data_be_o   = 4'hF;
                    data_addr_o = {addr_q[AW-1:2], 2'b00};
                end
                READ_RESP: begin
                    r_valid_o = 1'b1;
                    r_data_o  = rdata_q;
                    r_id_o    = id_q;
                    r_last_o  = last_beat;
                end
                WRITE_REQ: begin
                    data_req_o   = w_valid_i;
                    data_we_o    = 1'b1;
                    data_addr_o  = {addr_q[AW-1:2], 2'b00};
                    data_be_o    = w_strb_i;
                    data_wdata_o = w_data_i;
                    w_ready_o    = data_gnt_i;
                end
                WRITE_RESP: begin
                    b_valid_o = 1'b1;
                    b_id_o    = id_q;
                    b_resp_o  = err_q ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            burst_q <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
`ifdef AXI2CORE_RR_ARB_EN
            rd_last_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef AXI2CORE_RR_ARB_EN
            rd_last_q <= rd_last_d;
`endif
        end
    end
endmodule
